// File: rtl/alu_pkg.sv
// Shared opcode and FSM encodings for the multi-cycle ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_NOT = 4'd5,
        OP_ADC = 4'd6,
        OP_SHL = 4'd8,
        OP_SHR = 4'd9,
        OP_MUL = 4'd10
    } alu_op_t;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_t;

    // Result driven for opcodes 7 and 11..15; sliced to WIDTH by the user.
    localparam logic [31:0] ILLEGAL_RESULT = '0;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per clock, done pulses
// for one cycle once the full 2*WIDTH product sits in product.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic                 busy;
    logic [CW-1:0]        count;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;

    assign product = acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy   <= 1'b1;
                count  <= '0;
                acc    <= '0;
                mcand  <= {{WIDTH{1'b0}}, a};
                mplier <= b;
            end else if (busy) begin
                if (mplier[0]) begin
                    acc <= acc + mcand;
                end
                mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
                mplier <= {1'b0, mplier[WIDTH-1:1]};
                count  <= count + 1'b1;
                // The final iteration's accumulate lands together with done.
                if (count == LAST) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake: single-cycle ops load the
// output register at the accept edge, MUL runs through alu_mul_seq.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       alu_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             carry_out,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    localparam int MSB = WIDTH - 1;

    state_t               state;
    logic                 carry_reg;
    logic                 accept;
    logic                 mul_start;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_product;
    logic [WIDTH:0]       sum_ext;
    logic [WIDTH-1:0]     comb_res;
    logic                 comb_c;
    logic                 comb_v;

    assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (alu_sel == OP_MUL);
    assign zero      = (alu_out == '0);
    assign negative  = alu_out[MSB];

    alu_mul_seq #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (A),
        .b       (B),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        sum_ext  = '0;
        comb_res = '0;
        comb_c   = 1'b0;
        comb_v   = 1'b0;
        case (alu_sel)
            OP_ADD, OP_ADC: begin
                sum_ext  = {1'b0, A} + {1'b0, B}
                         + {{WIDTH{1'b0}}, (alu_sel == OP_ADC) && carry_reg};
                comb_res = sum_ext[WIDTH-1:0];
                comb_c   = sum_ext[WIDTH];
                comb_v   = (A[MSB] == B[MSB]) && (comb_res[MSB] != A[MSB]);
            end
            OP_SUB: begin
                comb_res = A - B;
                comb_c   = (A < B);
                comb_v   = (A[MSB] != B[MSB]) && (comb_res[MSB] != A[MSB]);
            end
            OP_AND: comb_res = A & B;
            OP_OR:  comb_res = A | B;
            OP_XOR: comb_res = A ^ B;
            OP_NOT: comb_res = ~A;
            OP_SHL: begin
                comb_res = {A[MSB-1:0], 1'b0};
                comb_c   = A[MSB];
            end
            OP_SHR: begin
                comb_res = {1'b0, A[MSB:1]};
                comb_c   = A[0];
            end
            default: comb_res = ILLEGAL_RESULT[WIDTH-1:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            alu_out   <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            carry_reg <= 1'b0;
        end else begin
            // A load later in this block overrides the consume-clear.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (alu_sel == OP_MUL) begin
                            state <= MUL_BUSY;
                        end else begin
                            alu_out   <= comb_res;
                            carry_out <= comb_c;
                            overflow  <= comb_v;
                            carry_reg <= comb_c;
                            out_valid <= 1'b1;
                        end
                    end
                end
                MUL_BUSY: begin
                    if (mul_done) begin
                        alu_out   <= mul_product[WIDTH-1:0];
                        carry_out <= |mul_product[2*WIDTH-1:WIDTH];
                        overflow  <= 1'b0;
                        carry_reg <= |mul_product[2*WIDTH-1:WIDTH];
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
